mem_agu: RTL and testbench

Parametrised, handshaked memory address generation unit for the load/store path. It aligns a base register value, adds a scaled, sign-extended offset, and emits either a single address or a burst of consecutive word addresses. Each address is registered, with a valid/ready interface toward the data-memory port. It replaces the purely combinational base+offset address calculation in the MEM stage and adds burst generation, backpressure, and wrap reporting.

---
 rtl/agu_pkg.sv | 20 ++
 rtl/cla_nbit.sv | 40 ++++
 rtl/mem_agu.sv | 171 +++++++++++++++++
 tb/tb_mem_agu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/agu_pkg.sv
// agu_pkg: shared types and helpers for the memory address generation unit.
//   agu_state_e : IDLE / EMIT state encoding
//   AGU_SINGLE / AGU_BURST : request mode encoding on req_burst
//   len_w()     : width of the beat-count field for a given MAX_BURST
package agu_pkg;

  localparam logic AGU_SINGLE = 1'b0;
  localparam logic AGU_BURST  = 1'b1;

  typedef enum logic {
    AGU_IDLE = 1'b0,
    AGU_EMIT = 1'b1
  } agu_state_e;

  // Beat-count width: enough to hold MAX_BURST itself.
  function automatic int unsigned len_w(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/cla_nbit.sv
// cla_nbit: parametrised parallel-prefix carry-lookahead adder.
//   a, b : W-bit operands
//   sum  : (a + b) mod 2^W
//   cout : carry out of bit W-1
module cla_nbit #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned LVLS = $clog2(W);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] gp;
  logic [W-1:0] pp;

  // Kogge-Stone prefix; descending i keeps each level reading the previous level's values.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gp = g;
    pp = p;
    for (int lvl = 0; lvl < int'(LVLS); lvl++) begin
      for (int i = int'(W) - 1; i >= 0; i--) begin
        if (i >= (1 << lvl)) begin
          gp[i] = gp[i] | (pp[i] & gp[i - (1 << lvl)]);
          pp[i] = pp[i] & pp[i - (1 << lvl)];
        end
      end
    end
  end

  assign sum  = p ^ {gp[W-2:0], 1'b0};
  assign cout = gp[W-1];

endmodule

// File: rtl/mem_agu.sv
// mem_agu: handshaked address generation unit for the load/store path.
// Aligns the base, adds a scaled signed offset, then emits one address or a
// burst of consecutive word addresses with per-beat wrap reporting.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : request channel (valid/ready, base, offset, mode, length)
//   addr_*            : beat channel toward the data-memory port (valid/ready)
//   addr_last         : final beat of the request
//   addr_wrap         : this beat's address wrapped modulo 2^ADDR_W
//   misalign          : base had nonzero low SHIFT bits
// Build option: define MEM_AGU_ALIGN_CHECK_EN to register and report misalign;
// otherwise misalign is tied low.
module mem_agu
  import agu_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 16,
  parameter  int unsigned OFF_W     = 4,
  parameter  int unsigned SHIFT     = 1,
  parameter  int unsigned MAX_BURST = 8,
  localparam int unsigned LEN_W     = len_w(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [OFF_W-1:0]  req_off,
  input  logic              req_burst,
  input  logic [LEN_W-1:0]  req_len,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_last,
  output logic              addr_wrap,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << SHIFT) - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(1 << SHIFT);

  agu_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic              wrap_q, wrap_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] off_scaled;
  logic [ADDR_W-1:0] op_a;
  logic [ADDR_W-1:0] op_b;
  logic [ADDR_W-1:0] sum;
  logic              cout;
  logic [LEN_W-1:0]  beats;
  logic              accept;

  assign off_scaled = {{(ADDR_W - OFF_W){req_off[OFF_W-1]}}, req_off} << SHIFT;
  assign accept     = (state_q == AGU_IDLE) && req_valid;

  // One shared adder: first address in IDLE, increment in EMIT.
  always_comb begin
    op_a = addr_q;
    op_b = STEP;
    if (state_q == AGU_IDLE) begin
      op_a = req_base & ALIGN_MASK;
      op_b = off_scaled;
    end
  end

  cla_nbit #(.W(ADDR_W)) u_cla (
    .a    (op_a),
    .b    (op_b),
    .sum  (sum),
    .cout (cout)
  );

  // Beat count: SINGLE is 1; BURST length 0 means 1, lengths above MAX_BURST clamp.
  always_comb begin
    beats = LEN_W'(1);
    if (req_burst == AGU_BURST) begin
      if (req_len == '0)                          beats = LEN_W'(1);
      else if (req_len > LEN_W'(MAX_BURST))       beats = LEN_W'(MAX_BURST);
      else                                        beats = req_len;
    end
  end

  // Next-state and registered outputs.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    last_d  = last_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      AGU_IDLE: begin
        if (req_valid) begin
          addr_d  = sum;
          // True sum outside [0, 2^ADDR_W): carry disagrees with offset sign.
          wrap_d  = cout ^ req_off[OFF_W-1];
          cnt_d   = beats;
          last_d  = (beats == LEN_W'(1));
          valid_d = 1'b1;
          state_d = AGU_EMIT;
        end
      end
      AGU_EMIT: begin
        if (addr_ready) begin
          if (cnt_q == LEN_W'(1)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = '0;
            state_d = AGU_IDLE;
          end else begin
            addr_d = sum;
            wrap_d = cout;
            cnt_d  = cnt_q - LEN_W'(1);
            last_d = (cnt_q == LEN_W'(2));
          end
        end
      end
      default: state_d = AGU_IDLE;
    endcase
    ready_d = (state_d == AGU_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= AGU_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_AGU_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Captured once per request, reported on every beat of it.
  always_comb begin
    misalign_d = misalign_q;
    if (accept) misalign_d = |req_base[SHIFT-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign req_ready  = ready_q;
  assign addr_valid = valid_q;
  assign addr_out   = addr_q;
  assign addr_last  = last_q;
  assign addr_wrap  = wrap_q;

endmodule

// File: tb/tb_mem_agu.sv
// tb_mem_agu: directed plus randomized checks of mem_agu (default parameters)
// against an integer-arithmetic reference model.
module tb_mem_agu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_base;
  logic [3:0]  req_off;
  logic        req_burst;
  logic [3:0]  req_len;
  logic        addr_valid;
  logic        addr_ready;
  logic [15:0] addr_out;
  logic        addr_last;
  logic        addr_wrap;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_agu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .req_off    (req_off),
    .req_burst  (req_burst),
    .req_len    (req_len),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .addr_last  (addr_last),
    .addr_wrap  (addr_wrap),
    .misalign   (misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow all its beats. Called 1 time unit after an edge
  // with the unit idle. stall_beat/stall_cycles force addr_ready low on that beat;
  // stall_pct adds random backpressure.
  task automatic do_req(input logic [15:0] base, input logic [3:0] off, input logic burst,
                        input logic [3:0] len, input int stall_pct,
                        input int stall_beat, input int stall_cycles);
    int          n;
    int          a;
    int          beat;
    int          stalled;
    int          budget;
    logic [15:0] exp_addr[$];
    logic        exp_wrap[$];
    logic        exp_mis;

    // Reference model: plain integer arithmetic on the address sequence.
    n = burst ? ((len == 0) ? 1 : ((len > 8) ? 8 : int'(len))) : 1;
    a = int'(base & 16'hFFFE) + int'($signed(off)) * 2;
    for (int i = 0; i < n; i++) begin
      exp_wrap.push_back((a < 0) || (a >= 65536));
      a = (a + 65536) % 65536;
      exp_addr.push_back(16'(a));
      a = a + 2;
    end
`ifdef MEM_AGU_ALIGN_CHECK_EN
    exp_mis = base[0];
`else
    exp_mis = 1'b0;
`endif

    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_base  = base;
    req_off   = off;
    req_burst = burst;
    req_len   = len;
    step();
    req_valid = 1'b0;
    req_base  = 16'($urandom);
    req_off   = 4'($urandom);
    req_len   = 4'($urandom);
    req_burst = 1'($urandom);

    beat    = 0;
    stalled = 0;
    budget  = 0;
    while (beat < n && budget < 200) begin
      budget++;
      check("beat_valid", 32'(addr_valid), 32'd1);
      check("beat_addr",  32'(addr_out),   32'(exp_addr[beat]));
      check("beat_last",  32'(addr_last),  32'(beat == n - 1));
      check("beat_wrap",  32'(addr_wrap),  32'(exp_wrap[beat]));
      check("beat_mis",   32'(misalign),   32'(exp_mis));
      check("busy_ready", 32'(req_ready),  32'd0);
      if (beat == stall_beat && stalled < stall_cycles) begin
        addr_ready = 1'b0;
        stalled++;
      end else begin
        addr_ready = ($urandom_range(99) >= 32'(stall_pct));
      end
      step();
      if (addr_ready) beat++;
    end
    check("beat_budget", 32'(beat), 32'(n));
    check("done_valid", 32'(addr_valid), 32'd0);
    check("done_ready", 32'(req_ready),  32'd1);
    addr_ready = 1'($urandom);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b1;   // must be ignored during reset
    req_base   = 16'h1234;
    req_off    = 4'h1;
    req_burst  = 1'b1;
    req_len    = 4'd4;
    addr_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_addr",  32'(addr_out),   32'd0);
    check("rst_last",  32'(addr_last),  32'd0);
    check("rst_wrap",  32'(addr_wrap),  32'd0);
    check("rst_mis",   32'(misalign),   32'd0);
    check("rst_ready", 32'(req_ready),  32'd1);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    step();
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_valid", 32'(addr_valid), 32'd0);

    // Directed cases.
    do_req(16'h1235, 4'hD, 1'b0, 4'd0, 0, -1, 0);
    do_req(16'h0002, 4'hE, 1'b0, 4'd0, 0, -1, 0);
    do_req(16'h00F0, 4'h0, 1'b1, 4'd4, 0, -1, 0);
    do_req(16'h00F0, 4'h0, 1'b1, 4'd4, 0, 1, 3);
    do_req(16'h00F0, 4'h0, 1'b1, 4'd0, 0, -1, 0);
    do_req(16'h00F0, 4'h0, 1'b1, 4'd12, 0, -1, 0);
    do_req(16'hFFFC, 4'h0, 1'b1, 4'd3, 0, -1, 0);
    do_req(16'hFFFE, 4'h7, 1'b1, 4'd8, 0, -1, 0);

    // Reset during beat 2 of a len-4 burst.
    req_valid = 1'b1;
    req_base  = 16'h00F0;
    req_off   = 4'h0;
    req_burst = 1'b1;
    req_len   = 4'd4;
    addr_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("mid_beat2_addr", 32'(addr_out), 32'h00F2);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(addr_valid), 32'd0);
    check("mid_rst_addr",  32'(addr_out),   32'd0);
    check("mid_rst_ready", 32'(req_ready),  32'd1);
    rst_n = 1'b1;
    step();
    do_req(16'h0100, 4'h3, 1'b1, 4'd2, 0, -1, 0);

    // Randomized requests with random backpressure.
    for (int k = 0; k < 60; k++) begin
      do_req(16'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 30, -1, 0);
      if ($urandom_range(1) == 1) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
